// File: rtl/acfa_mem_map_pkg.sv
// Shared memory-map constants, address type and DMA engine state encoding.
// The protected-region constants are the same ones the RoT monitors use.
package acfa_mem_map_pkg;

  typedef logic [15:0] addr_t;

  localparam addr_t SDATA_BASE = 16'h0B00;
  localparam addr_t SDATA_SIZE = 16'h0C00;
  localparam addr_t CTR_BASE   = 16'hFFC0;
  localparam addr_t CTR_SIZE   = 16'h001F;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_FIN  = 3'd3,
    ST_ABT  = 3'd4
  } dma_state_e;

  // Half-open [base, base+size) membership, evaluated in 17 bits so a region
  // touching the top of the address space cannot wrap.
  function automatic logic in_region(input addr_t a, input addr_t base, input addr_t size);
    logic [16:0] lo;
    logic [16:0] hi;
    logic [16:0] x;
    lo = {1'b0, base};
    hi = {1'b0, base} + {1'b0, size};
    x  = {1'b0, a};
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/dma_range_guard.sv
// Combinational protected-region check: flags an address that falls inside
// either the stack/data region or the counter region.
import acfa_mem_map_pkg::*;

module dma_range_guard #(
  parameter addr_t R0_BASE = SDATA_BASE,
  parameter addr_t R0_SIZE = SDATA_SIZE,
  parameter addr_t R1_BASE = CTR_BASE,
  parameter addr_t R1_SIZE = CTR_SIZE
) (
  input  logic [15:0] addr,
  output logic        hit
);

  assign hit = in_region(addr, R0_BASE, R0_SIZE) || in_region(addr, R1_BASE, R1_SIZE);

endmodule

// File: rtl/dma_copy_master.sv
// Word-copy DMA initiator: one read beat then one write beat per 16-bit word.
// Optional build macro DMA_COPY_GUARD_EN: checks each beat address against the
// protected regions before issuing it and aborts instead of touching them.
import acfa_mem_map_pkg::*;

module dma_copy_master #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [15:0]      cfg_src,
  input  logic [15:0]      cfg_dst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             rot_kill,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [15:0]      dma_addr,
  output logic             dma_en,
  output logic             dma_we,
  output logic [15:0]      dma_dout,
  input  logic [15:0]      dma_din,
  input  logic             dma_ready
);

  dma_state_e       state_q, state_d;
  addr_t            src_q, dst_q;
  logic [LEN_W-1:0] cnt_q;
  logic [15:0]      data_q;
  logic             err_q;
  logic             src_ovf_q;

  logic accept, rd_done, wr_done;
  logic src_hit, dst_hit;

  assign accept  = (state_q == ST_IDLE) && start && !rot_kill;
  assign rd_done = (state_q == ST_RD) && dma_ready && !rot_kill;
  assign wr_done = (state_q == ST_WR) && dma_ready && !rot_kill;

`ifdef DMA_COPY_GUARD_EN
  addr_t guard_src, guard_dst;

  // In IDLE the guards look at the incoming job; afterwards at the next beat addresses.
  assign guard_src = (state_q == ST_IDLE) ? (cfg_src & 16'hFFFE) : src_q;
  assign guard_dst = (state_q == ST_IDLE) ? (cfg_dst & 16'hFFFE) : dst_q;

  dma_range_guard u_guard_src (.addr(guard_src), .hit(src_hit));
  dma_range_guard u_guard_dst (.addr(guard_dst), .hit(dst_hit));
`else
  assign src_hit = 1'b0;
  assign dst_hit = 1'b0;
`endif

  // Next-state selection; kill wins over everything outside IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cfg_len == '0)          state_d = ST_FIN;
          else if (src_hit || dst_hit) state_d = ST_ABT;
          else                         state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (rot_kill)       state_d = ST_ABT;
        else if (dma_ready) state_d = dst_hit ? ST_ABT : ST_WR;
      end
      ST_WR: begin
        if (rot_kill) state_d = ST_ABT;
        else if (dma_ready) begin
          if (cnt_q == LEN_W'(1))                   state_d = ST_FIN;
          else if (src_ovf_q || dst_q == 16'hFFFE) state_d = ST_ABT;
          else if (src_hit)                         state_d = ST_ABT;
          else                                      state_d = ST_RD;
        end
      end
      ST_FIN:  state_d = rot_kill ? ST_ABT : ST_IDLE;
      ST_ABT:  state_d = rot_kill ? ST_ABT : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, address/count bookkeeping, read-data capture and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      src_ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_ABT) err_q <= 1'b1;
      else if (accept)       err_q <= 1'b0;
      if (accept) begin
        src_q     <= cfg_src & 16'hFFFE;
        dst_q     <= cfg_dst & 16'hFFFE;
        cnt_q     <= cfg_len;
        src_ovf_q <= 1'b0;
      end
      if (rd_done) begin
        data_q    <= dma_din;
        src_q     <= src_q + 16'd2;
        src_ovf_q <= (src_q == 16'hFFFE);
      end
      if (wr_done) begin
        dst_q <= dst_q + 16'd2;
        cnt_q <= cnt_q - LEN_W'(1);
      end
    end
  end

  // Bus and status outputs decode straight from state so reset releases the bus at once.
  always_comb begin
    dma_en   = (state_q == ST_RD) || (state_q == ST_WR);
    dma_we   = (state_q == ST_WR);
    dma_addr = '0;
    if (state_q == ST_RD) dma_addr = src_q;
    if (state_q == ST_WR) dma_addr = dst_q;
    dma_dout = data_q;
    busy     = dma_en;
    done     = (state_q == ST_FIN);
    err      = err_q;
  end

endmodule

// File: tb/tb_dma_copy_master.sv
// Directed bench for dma_copy_master: table of copy jobs plus hand-written
// sequences for wait states, kill, start/kill collision and async reset.
module tb_dma_copy_master;

  logic        clk = 1'b0;
  logic        reset_n, start, rot_kill, dma_ready;
  logic [15:0] cfg_src, cfg_dst, cfg_len;
  logic        busy, done, err, dma_en, dma_we;
  logic [15:0] dma_addr, dma_dout, dma_din;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  dma_copy_master #(.LEN_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .rot_kill(rot_kill), .busy(busy), .done(done), .err(err),
    .dma_addr(dma_addr), .dma_en(dma_en), .dma_we(dma_we),
    .dma_dout(dma_dout), .dma_din(dma_din), .dma_ready(dma_ready)
  );

  logic [15:0] mem [0:32767];
  assign dma_din = mem[dma_addr[15:1]];

  typedef struct { logic we; logic [15:0] addr; logic [15:0] data; } beat_t;
  beat_t blog[$];

  always @(posedge clk)
    if (reset_n && dma_en && dma_ready)
      blog.push_back('{dma_we, dma_addr, dma_we ? dma_dout : dma_din});

  typedef struct {
    logic [15:0] src, dst, len, esrc, edst;
    int          nbeats;
    logic        eerr;
    int          edone;
  } vec_t;

  localparam int NV = 10;
  vec_t vt [NV];

  function automatic logic [15:0] pat(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic run_job(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                         output int dcnt, output bit timeout);
    @(negedge clk);
    cfg_src = s; cfg_dst = d; cfg_len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0; timeout = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (done) dcnt++;
      if (!busy) begin timeout = 1'b0; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    int          dcnt, b0, nb, j;
    bit          to;
    logic [15:0] ea;
    logic [15:0] sv [4];

    for (int i = 0; i < 32768; i++) mem[i] = pat(16'(i * 2));
    reset_n = 1'b0; start = 1'b0; rot_kill = 1'b0; dma_ready = 1'b1;
    cfg_src = '0; cfg_dst = '0; cfg_len = '0;

    //                 src       dst       len    esrc      edst    beats err done
    vt[0] = '{16'h0200, 16'h0400, 16'd3, 16'h0200, 16'h0400, 6, 1'b0, 1};
    vt[1] = '{16'h0201, 16'h0401, 16'd2, 16'h0200, 16'h0400, 4, 1'b0, 1};
    vt[2] = '{16'h0300, 16'h0500, 16'd0, 16'h0300, 16'h0500, 0, 1'b0, 1};
    vt[3] = '{16'hFFFC, 16'h0600, 16'd2, 16'hFFFC, 16'h0600, 4, 1'b0, 1};
    vt[4] = '{16'hFFFE, 16'h0700, 16'd2, 16'hFFFE, 16'h0700, 2, 1'b1, 0};
    vt[5] = '{16'h0800, 16'hFFFE, 16'd2, 16'h0800, 16'hFFFE, 2, 1'b1, 0};
    vt[6] = '{16'h1700, 16'h1800, 16'd1, 16'h1700, 16'h1800, 2, 1'b0, 1};
`ifdef DMA_COPY_GUARD_EN
    vt[7] = '{16'h0210, 16'h0B10, 16'd2, 16'h0210, 16'h0B10, 0, 1'b1, 0};
    vt[8] = '{16'h0220, 16'hFFC4, 16'd1, 16'h0220, 16'hFFC4, 0, 1'b1, 0};
    vt[9] = '{16'h0AFE, 16'h0900, 16'd2, 16'h0AFE, 16'h0900, 2, 1'b1, 0};
`else
    vt[7] = '{16'h0210, 16'h0B10, 16'd2, 16'h0210, 16'h0B10, 4, 1'b0, 1};
    vt[8] = '{16'h0220, 16'hFFC4, 16'd1, 16'h0220, 16'hFFC4, 2, 1'b0, 1};
    vt[9] = '{16'h0AFE, 16'h0900, 16'd2, 16'h0AFE, 16'h0900, 4, 1'b0, 1};
`endif

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_status", {29'd0, busy, done, err}, 32'd0);
    chk("rst_bus", {14'd0, dma_en, dma_we, dma_addr}, 32'd0);
    chk("rst_dout", {16'd0, dma_dout}, 32'd0);
    reset_n = 1'b1;

    // Table-driven jobs, dma_ready tied high
    for (int v = 0; v < NV; v++) begin
      b0 = blog.size();
      run_job(vt[v].src, vt[v].dst, vt[v].len, dcnt, to);
      nb = blog.size() - b0;
      chk($sformatf("v%0d_timeout", v), {31'd0, to}, 32'd0);
      chk($sformatf("v%0d_nbeats", v), nb, vt[v].nbeats);
      for (int k = 0; k < nb && k < vt[v].nbeats; k++) begin
        j  = k / 2;
        ea = (k % 2 == 1) ? vt[v].edst + 16'(2 * j) : vt[v].esrc + 16'(2 * j);
        chk($sformatf("v%0d_beat%0d", v, k), {15'd0, blog[b0+k].we, blog[b0+k].addr},
            {15'd0, 1'(k % 2), ea});
        if (k % 2 == 1)
          chk($sformatf("v%0d_wdata%0d", v, k), {16'd0, blog[b0+k].data},
              {16'd0, pat(vt[v].esrc + 16'(2 * j))});
      end
      chk($sformatf("v%0d_err", v), {31'd0, err}, {31'd0, vt[v].eerr});
      chk($sformatf("v%0d_done", v), dcnt, vt[v].edone);
      chk($sformatf("v%0d_idle", v), {30'd0, busy, dma_en}, 32'd0);
    end

    // Wait states on the read: address held, data taken only on the ready edge
    sv[0] = 16'h1111; sv[1] = 16'h2222; sv[2] = 16'h3333; sv[3] = 16'h4444;
    @(negedge clk);
    cfg_src = 16'h0200; cfg_dst = 16'h0400; cfg_len = 16'd1; start = 1'b1; dma_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ws_hold%0d", i), {15'd0, dma_en, dma_we, dma_addr}, {15'd0, 1'b1, 1'b0, 16'h0200});
      mem[16'h0200 >> 1] = sv[i];
      if (i == 3) dma_ready = 1'b1;
      @(negedge clk);
    end
    chk("ws_write", {dma_we, dma_addr[14:0], dma_dout}, {1'b1, 15'h0400, 16'h4444});
    @(negedge clk);
    chk("ws_done", {30'd0, done, busy}, 32'd2);
    mem[16'h0200 >> 1] = pat(16'h0200);
    @(negedge clk);

    // Kill during the second write; a start while busy is ignored
    cfg_src = 16'h0200; cfg_dst = 16'h0400; cfg_len = 16'd3; start = 1'b1;
    @(negedge clk);                 // RD 0200
    start = 1'b0;
    @(negedge clk);                 // WR 0400
    cfg_len = 16'd0; start = 1'b1;
    @(negedge clk);                 // RD 0202
    start = 1'b0;
    chk("busy_start_ign", {15'd0, dma_en, dma_we, dma_addr}, {15'd0, 1'b1, 1'b0, 16'h0202});
    @(negedge clk);                 // WR 0402
    chk("kill_at_wr2", {15'd0, dma_we, dma_addr[15:0], busy}, {15'd0, 1'b1, 16'h0402, 1'b1});
    rot_kill = 1'b1;
    @(negedge clk);
    chk("kill_bus", {30'd0, dma_en, busy}, 32'd0);
    chk("kill_err", {30'd0, err, done}, 32'd2);
    rot_kill = 1'b0;
    @(negedge clk);
    cfg_src = 16'h0300; cfg_dst = 16'h0500; cfg_len = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_clr", {30'd0, busy, err}, 32'd2);
    dcnt = 0; to = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (done) begin dcnt++; to = 1'b0; break; end
      @(negedge clk);
    end
    chk("restart_timeout", {31'd0, to}, 32'd0);
    chk("restart_done", {30'd0, 1'(dcnt), err}, 32'd2);
    @(negedge clk);

    // start together with rot_kill in IDLE is ignored
    cfg_len = 16'd1; start = 1'b1; rot_kill = 1'b1;
    @(negedge clk);
    start = 1'b0; rot_kill = 1'b0;
    chk("start_kill_idle", {29'd0, busy, done, dma_en}, 32'd0);
    @(negedge clk);

    // Asynchronous reset mid-job releases the bus between edges
    cfg_src = 16'h0200; cfg_dst = 16'h0400; cfg_len = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_bus", {14'd0, dma_en, busy, dma_addr}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {29'd0, busy, done, err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
